// File: rtl/down_timer_pkg.sv
// Shared types and constants for the arbitrated down-count timer.
// State enum, default sizes and the round-robin pointer width helper.
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/down_timer_arbiter_rr.sv
// Combinational round-robin picker: first set req bit from ptr upward.
// Ports: req, ptr in; winner index and valid flag out.
module rr_arbiter
  import down_timer_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = ptr_w(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        winner = PW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/down_timer_arbiter.sv
// One shared down-count timer granted round-robin to NREQ requesters.
// Ports: clk, rst (async low), req, load_val, tick, abort in; grant, busy, count, done out.
module down_timer_arbiter
  import down_timer_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  tick,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  localparam int PW = ptr_w(NREQ);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   pick;
  logic            pick_ok;
  logic [PW-1:0]   win_nxt;
  logic [NREQ-1:0] pick_oh;
  logic [WIDTH-1:0] pick_val;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_ok)
  );

  assign win_nxt  = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << pick;
  assign pick_val = load_val[int'(pick)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      count <= '0;
      done  <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            win   <= pick;
            count <= pick_val;
            grant <= pick_oh;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Abort and withdrawal both beat expiry and tick.
          if (abort || !req[win]) begin
            grant <= '0;
            count <= '0;
            busy  <= 1'b0;
            ptr   <= win_nxt;
            state <= IDLE;
          end else if (count == '0) begin
            done[win] <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else if (tick) begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          ptr   <= win_nxt;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer_arbiter.sv
// Random and directed checks of down_timer_arbiter against a lifecycle model.
// Model tracks owner, remaining count and expiry from the block's rules.
module tb_down_timer_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] load_val = '0;
  logic           tick = 1'b0;
  logic           abort = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic [W-1:0]   count;
  logic [N-1:0]   done;

  down_timer_arbiter #(
    .NREQ  (N),
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
    .tick     (tick),
    .abort    (abort),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Model: owner index (-1 free), remaining count, expiry cycle flag.
  int m_own = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_fin = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lv(input int i);
    logic [N*W-1:0] v;
    v = load_val;
    return int'(v[i*W +: W]);
  endfunction

  task automatic model_edge();
    if (m_fin) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
      m_fin = 1'b0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_own < 0 && req[j]) begin
          m_own = j;
          m_cnt = lv(j);
        end
      end
    end else if (abort || !req[m_own]) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      m_fin = 1'b1;
    end else if (tick) begin
      m_cnt = m_cnt - 1;
    end
  endtask

  task automatic step();
    int eg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    eg = (m_own >= 0) ? (1 << m_own) : 0;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_own >= 0 && !m_fin));
    chk("count", 32'(count), 32'(m_cnt));
    chk("done", 32'(done), m_fin ? 32'(eg) : 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    abort = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_own = -1;
    m_cnt = 0;
    m_ptr = 0;
    m_fin = 1'b0;
  endtask

  int nseen;
  int ndone;
  logic [N-1:0] prev_g;
  logic [N-1:0] order [5];
  bit hit;

  initial begin
    // Reset state
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    do_reset();

    // Single requester, load 3, tick held
    load_val = 16'h0003;
    req = 4'b0001;
    tick = 1'b1;
    repeat (8) step();
    req = '0;
    step();

    // Fairness: all requesting, all preloads 1
    do_reset();
    load_val = 16'h1111;
    req = 4'b1111;
    tick = 1'b1;
    nseen = 0;
    ndone = 0;
    prev_g = '0;
    for (int c = 0; c < 40 && nseen < 5; c++) begin
      step();
      if (done != '0) ndone++;
      if (grant != '0 && prev_g == '0) begin
        order[nseen] = grant;
        nseen++;
      end
      prev_g = grant;
    end
    chk("fair_cnt", 32'(nseen), 32'd5);
    chk("fair_0", 32'(order[0]), 32'h1);
    chk("fair_1", 32'(order[1]), 32'h2);
    chk("fair_2", 32'(order[2]), 32'h4);
    chk("fair_3", 32'(order[3]), 32'h8);
    chk("fair_4", 32'(order[4]), 32'h1);
    chk("fair_done", 32'(ndone), 32'd4);
    req = '0;
    repeat (4) step();

    // Zero preload, no tick
    do_reset();
    load_val = 16'h0000;
    req = 4'b0100;
    tick = 1'b0;
    step();
    chk("z_busy", 32'(busy), 32'd1);
    step();
    chk("z_done", 32'(done), 32'h4);
    req = '0;
    repeat (2) step();

    // Abort at count 5 with tick
    do_reset();
    load_val = 16'h0099;
    req = 4'b0011;
    tick = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      step();
      if (count == 4'd5) hit = 1'b1;
    end
    chk("ab_reach5", 32'(hit), 32'd1);
    abort = 1'b1;
    step();
    chk("ab_grant", 32'(grant), 32'd0);
    abort = 1'b0;
    step();
    chk("ab_next", 32'(grant), 32'h2);
    req = 4'b0000;
    step();

    // Gated tick then withdrawal
    do_reset();
    load_val = 16'h0006;
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick = c[0];
      step();
    end
    req = 4'b0000;
    step();
    chk("wd_busy", 32'(busy), 32'd0);
    repeat (2) step();

    // Asynchronous reset mid-run
    load_val = 16'h00F0;
    req = 4'b0010;
    tick = 1'b1;
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    m_own = -1;
    m_cnt = 0;
    m_ptr = 0;
    m_fin = 1'b0;
    @(negedge clk);
    req = 4'b1010;
    rst = 1'b1;
    step();
    chk("ar_first", 32'(grant), 32'h2);

    // Random stimulus against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      if ($urandom_range(3) == 0) load_val = N*W'($urandom);
      tick = ($urandom_range(3) != 0);
      abort = ($urandom_range(19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
